// File: rtl/data_memory_responder.sv
// Multi-cycle data memory responder for the MEM stage: one little-endian 64-bit
// load/store at a time, LATENCY wait states, response held until consumed.
module data_memory_responder #(
    parameter int unsigned DEPTH_BYTES = 64,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);
    localparam int unsigned AW = (DEPTH_BYTES > 8) ? $clog2(DEPTH_BYTES) : 3;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_write;
    logic [63:0] lat_addr;
    logic [63:0] lat_wdata;
    logic [7:0]  mem [DEPTH_BYTES];

    logic        acc_write;
    logic [63:0] acc_addr;
    logic [63:0] acc_wdata;
    logic        acc_err;
    logic [63:0] acc_rdata;

    // With zero wait states the access happens on the accept edge, so it must
    // use the live request rather than the latched copy.
    always_comb begin
        acc_write = lat_write;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        if (state == IDLE) begin
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end
        acc_err   = (acc_addr[2:0] != 3'd0) || (acc_addr > 64'(DEPTH_BYTES - 8));
        acc_rdata = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            acc_rdata[8*i +: 8] = mem[acc_addr[AW-1:0] + AW'(i)];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
            for (int unsigned i = 0; i < DEPTH_BYTES; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (LATENCY == 0) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= acc_err;
                            resp_rdata <= (acc_err || acc_write) ? '0 : acc_rdata;
                            if (!acc_err && acc_write) begin
                                for (int unsigned i = 0; i < 8; i++) begin
                                    mem[acc_addr[AW-1:0] + AW'(i)] <= acc_wdata[8*i +: 8];
                                end
                            end
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(LATENCY);
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= acc_err;
                        resp_rdata <= (acc_err || acc_write) ? '0 : acc_rdata;
                        if (!acc_err && acc_write) begin
                            for (int unsigned i = 0; i < 8; i++) begin
                                mem[acc_addr[AW-1:0] + AW'(i)] <= acc_wdata[8*i +: 8];
                            end
                        end
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: directed vector table, reset corner cases and
// randomized traffic against a byte-array model, on LATENCY=2 and LATENCY=0 instances.
module tb_data_memory_responder;
    localparam int unsigned DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [2];
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_ready;
    logic        req_ready [2];
    logic        resp_valid [2];
    logic [63:0] resp_rdata [2];
    logic        resp_err [2];
    logic        busy [2];

    logic [7:0]  model_mem [2][DEPTH];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    data_memory_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(2)) dut_lat2 (
        .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready), .resp_rdata(resp_rdata[0]),
        .resp_err(resp_err[0]), .busy(busy[0])
    );

    data_memory_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(0)) dut_lat0 (
        .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready), .resp_rdata(resp_rdata[1]),
        .resp_err(resp_err[1]), .busy(busy[1])
    );

    typedef struct {
        bit          wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          hold;
        logic [63:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < int'(DEPTH); i++) model_mem[s][i] = 8'h00;
    endtask

    task automatic check_idle(input int s, input string tag);
        check({tag, "_req_ready"}, 64'(req_ready[s]), 64'd1);
        check({tag, "_resp_valid"}, 64'(resp_valid[s]), 64'd0);
        check({tag, "_busy"}, 64'(busy[s]), 64'd0);
        check({tag, "_rdata"}, resp_rdata[s], 64'd0);
        check({tag, "_err"}, 64'(resp_err[s]), 64'd0);
    endtask

    // One full transaction on instance s; expectation comes from the byte model.
    task automatic txn(input int s, input bit wr, input logic [63:0] addr,
                       input logic [63:0] wdata, input int hold,
                       output logic [63:0] got_rdata, output logic got_err);
        int          lat;
        int          k;
        int          base;
        logic        exp_err;
        logic [63:0] exp_rd;
        lat     = (s == 0) ? 2 : 0;
        exp_err = (addr[2:0] != 3'd0) || (addr > 64'(DEPTH - 8));
        exp_rd  = '0;
        if (!exp_err) begin
            base = int'(addr[5:0]);
            for (int i = 0; i < 8; i++) begin
                if (wr) model_mem[s][base + i] = wdata[8*i +: 8];
                else    exp_rd[8*i +: 8] = model_mem[s][base + i];
            end
        end
        @(negedge clk);
        check("accept_req_ready", 64'(req_ready[s]), 64'd1);
        req_valid[s] = 1'b1;
        req_write    = wr;
        req_addr     = addr;
        req_wdata    = wdata;
        resp_ready   = (hold == 0);
        @(negedge clk);
        req_valid[s] = 1'b0;
        req_write    = ~wr;
        req_addr     = {$urandom, $urandom};
        req_wdata    = {$urandom, $urandom};
        k = 1;
        while (!resp_valid[s] && k < 40) begin
            check("wait_busy", 64'(busy[s]), 64'd1);
            check("wait_req_ready", 64'(req_ready[s]), 64'd0);
            @(negedge clk);
            k++;
        end
        check("latency", 64'(k), 64'(lat + 1));
        check("resp_rdata", resp_rdata[s], exp_rd);
        check("resp_err", 64'(resp_err[s]), 64'(exp_err));
        got_rdata = resp_rdata[s];
        got_err   = resp_err[s];
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 64'(resp_valid[s]), 64'd1);
            check("hold_rdata", resp_rdata[s], exp_rd);
            check("hold_err", 64'(resp_err[s]), 64'(exp_err));
            check("hold_req_ready", 64'(req_ready[s]), 64'd0);
            req_valid[s] = 1'($urandom);
            req_addr     = {$urandom, $urandom};
        end
        if (hold > 0) begin
            req_valid[s] = 1'b0;
            resp_ready   = 1'b1;
        end
        @(negedge clk);
        check_idle(s, "release");
    endtask

    vec_t        vecs [11];
    logic [63:0] got_rd;
    logic        got_err;
    int          k;

    initial begin
        vecs[0]  = '{1'b1, 64'h00, 64'h00000000000000FF, 0, 64'h0, 1'b0};
        vecs[1]  = '{1'b0, 64'h00, 64'h0, 0, 64'h00000000000000FF, 1'b0};
        vecs[2]  = '{1'b0, 64'h08, 64'h0, 0, 64'h0, 1'b0};
        vecs[3]  = '{1'b1, 64'h08, 64'h1122334455667788, 0, 64'h0, 1'b0};
        vecs[4]  = '{1'b0, 64'h08, 64'h0, 5, 64'h1122334455667788, 1'b0};
        vecs[5]  = '{1'b0, 64'h04, 64'h0, 0, 64'h0, 1'b1};
        vecs[6]  = '{1'b0, 64'h40, 64'h0, 0, 64'h0, 1'b1};
        vecs[7]  = '{1'b1, 64'h03, 64'h5555555555555555, 0, 64'h0, 1'b1};
        vecs[8]  = '{1'b1, 64'hFFFFFFFFFFFFFFF8, 64'hAAAAAAAAAAAAAAAA, 0, 64'h0, 1'b1};
        vecs[9]  = '{1'b0, 64'h00, 64'h0, 2, 64'h00000000000000FF, 1'b0};
        vecs[10] = '{1'b0, 64'h38, 64'h0, 0, 64'h0, 1'b0};

        reset        = 1'b0;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        req_write    = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        resp_ready   = 1'b1;
        clear_model();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle(0, "reset_l2");
        check_idle(1, "reset_l0");

        for (int v = 0; v < 11; v++) begin
            txn(0, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].hold, got_rd, got_err);
            check($sformatf("vec%0d_rdata", v), got_rd, vecs[v].exp_rdata);
            check($sformatf("vec%0d_err", v), 64'(got_err), 64'(vecs[v].exp_err));
        end

        // Reset while a store is still waiting: the store must never land.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write    = 1'b1;
        req_addr     = 64'h10;
        req_wdata    = 64'hDEADBEEF;
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("midwait_busy", 64'(busy[0]), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        clear_model();
        check_idle(0, "midwait_reset");
        txn(0, 1'b0, 64'h10, 64'h0, 0, got_rd, got_err);
        check("midwait_load", got_rd, 64'h0);
        txn(0, 1'b0, 64'h08, 64'h0, 0, got_rd, got_err);
        check("cleared_load", got_rd, 64'h0);

        // Reset while a response is pending: the response is discarded.
        txn(0, 1'b1, 64'h18, 64'hCAFEF00D12345678, 0, got_rd, got_err);
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write    = 1'b0;
        req_addr     = 64'h18;
        resp_ready   = 1'b0;
        @(negedge clk);
        req_valid[0] = 1'b0;
        k = 0;
        while (!resp_valid[0] && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("midresp_valid", 64'(resp_valid[0]), 64'd1);
        check("midresp_rdata", resp_rdata[0], 64'hCAFEF00D12345678);
        reset = 1'b0;
        @(negedge clk);
        reset      = 1'b1;
        resp_ready = 1'b1;
        clear_model();
        check_idle(0, "midresp_reset");
        txn(0, 1'b0, 64'h18, 64'h0, 0, got_rd, got_err);
        check("midresp_load", got_rd, 64'h0);

        // Zero wait states.
        txn(1, 1'b1, 64'h38, 64'h0123456789ABCDEF, 0, got_rd, got_err);
        txn(1, 1'b0, 64'h38, 64'h0, 0, got_rd, got_err);
        check("lat0_load", got_rd, 64'h0123456789ABCDEF);
        txn(1, 1'b0, 64'h39, 64'h0, 1, got_rd, got_err);
        check("lat0_misaligned", 64'(got_err), 64'd1);

        for (int n = 0; n < 60; n++) begin
            logic [63:0] a;
            int          sel;
            int          kind;
            sel  = int'($urandom_range(1, 0));
            kind = int'($urandom_range(9, 0));
            if (kind < 7)       a = 64'(8 * $urandom_range(7, 0));
            else if (kind == 7) a = 64'($urandom_range(63, 0));
            else if (kind == 8) a = 64'(64 + 8 * $urandom_range(20, 0));
            else                a = {$urandom, $urandom};
            txn(sel, 1'($urandom), a, {$urandom, $urandom}, int'($urandom_range(3, 0)),
                got_rd, got_err);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
